systolic_ws_matmul_3x3: RTL
===========================

Name: systolic_ws_matmul_3x3

Overview:
- Weight-stationary 3x3 systolic matrix multiplier; computes C = A x B.
- Sits directly downstream of the weight cache. The cache's fixed B outputs fix_b11..fix_b33 drive this block's B inputs.
- A operand is presented in parallel and captured at start. The block skews A rows into a 3x3 PE grid, accumulates partial sums down the columns, de-skews the results and presents all nine C elements with a one-cycle done pulse.

Parameters:
- DATA_W, 8, width of each A and B element.
- ACC_W, 2*DATA_W+2, width of each C element; sized so that 3 full-scale products never overflow.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- a11..a33  input  DATA_W each (9 ports)  A matrix elements, row-major.
- fix_b11..fix_b33  input  DATA_W each (9 ports)  B matrix elements from the weight cache, row-major.
- c11..c33  output  ACC_W each (9 ports)  result matrix, row-major.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; c11..c33 hold the new result from this cycle on.

Behaviour:
- Reset (synchronous, active-high): FSM to IDLE; busy=0, done=0; c11..c33=0; all PE registers, skew registers and counters cleared.
- Reset mid-operation: the computation is aborted; C returns to 0 and no done pulse is produced.
- FSM states:
  - IDLE: start=1 latches A[0..8] and B[0..8] into internal registers, clears the cycle counter and goes to RUN. start=0 stays in IDLE.
  - RUN: the cycle counter increments every cycle. When counter==8, go to DONE.
  - DONE: done=1 for exactly one cycle, then back to IDLE.
- Handshake rules:
  - start is ignored whenever the FSM is not in IDLE; no queuing.
  - Back-to-back operation: a start in the cycle after done (FSM in IDLE) is accepted.
- Weight-stationary mapping:
  - PE(k,j) holds b_kj for the whole operation; b_kj is the latched copy, so cache changes during RUN have no effect.
  - a_ik is injected into the left edge of row k at RUN cycle i+k, where i = A row index and k = 0..2.
  - Each PE registers a to the right and registers psum_out = psum_in + a*b_kj downward.
  - psum_in of row 0 is 0.
  - Bottom of column j produces c_ij at RUN cycle i+j+3.
  - An output de-skew stage captures each c_ij into its output register as it emerges.
- Latency: start sampled high at edge N. done is high in the cycle following edge N+10, and c11..c33 are valid and stable from that cycle.
- c outputs retain the previous result throughout RUN. They are updated atomically: shadow registers are copied to c11..c33 on the DONE transition, so intermediate partial values are never visible.
- Arithmetic (default, unsigned):
  - Operands are zero-extended to ACC_W before multiply/accumulate.
  - No saturation is needed, since 3*(2^DATA_W-1)^2 < 2^ACC_W.
- Idle-cycle injection: idle skew slots inject a=0, so an unused slot contributes nothing to any sum.

Optional Feature:
- Macro: SYSTOLIC_SIGNED_EN.
- Defined:
  - A and B are two's-complement.
  - Operands are sign-extended to ACC_W, products are signed, and c outputs are two's-complement.
  - Range: 3*(-128*-128)=49152 fits ACC_W=18 signed.
- Undefined: unsigned arithmetic as above.
- Timing and FSM are identical in both builds.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> busy=0, done=0, all c=0. start held 0 for 20 cycles -> no done.
- Identity B (b11=b22=b33=1, others 0), A=1..9 row-major, pulse start -> done exactly 10 cycles after the start edge; c11..c33 = 1..9; busy high for the 10 cycles before done.
- Full scale (unsigned build): all A=255, all B=255 -> every c = 195075. A=[1,2,3;4,5,6;7,8,9], B=[9,8,7;6,5,4;3,2,1] -> C=[30,24,18;84,69,54;138,114,90].
- start re-asserted during RUN, and fix_b changed mid-RUN -> single done pulse; result uses the A and B latched at the first start. A start in the cycle after done launches a second run with a correct second result.
- Reset asserted at RUN cycle 4 -> c=0, busy=0, no done pulse; a following start gives a correct result.
- SYSTOLIC_SIGNED_EN build: all A=-128, all B=-128 -> c=49152. A row0=[-1,2,-3] with B=identity -> c11=-1, c12=2, c13=-3.

Source files
------------

// File: rtl/systolic_ws_matmul_3x3.sv
// Weight-stationary 3x3 systolic matrix multiplier, C = A x B, with skewed A injection and atomic C update.
// Define SYSTOLIC_SIGNED_EN for two's-complement operands and results; default build is unsigned.
module systolic_ws_matmul_3x3 #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W+2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a11, a12, a13, a21, a22, a23, a31, a32, a33,
    input  logic [DATA_W-1:0] fix_b11, fix_b12, fix_b13, fix_b21, fix_b22, fix_b23,
    input  logic [DATA_W-1:0] fix_b31, fix_b32, fix_b33,
    output logic [ACC_W-1:0]  c11, c12, c13, c21, c22, c23, c31, c32, c33,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              load;
    logic              done_reg;
    logic [DATA_W-1:0] a_in [9];
    logic [DATA_W-1:0] b_in [9];
    logic [DATA_W-1:0] a_lat_reg [9];
    logic [DATA_W-1:0] b_lat_reg [9];
    logic [ACC_W-1:0]  a_edge [3];
    logic [ACC_W-1:0]  pe_a [3][3];
    logic [ACC_W-1:0]  pe_psum [3][3];
    logic [ACC_W-1:0]  shadow_reg [9];
    logic [ACC_W-1:0]  c_reg [9];

    function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
`ifdef SYSTOLIC_SIGNED_EN
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
`else
        return {{(ACC_W-DATA_W){1'b0}}, v};
`endif
    endfunction

    assign a_in = '{a11, a12, a13, a21, a22, a23, a31, a32, a33};
    assign b_in = '{fix_b11, fix_b12, fix_b13, fix_b21, fix_b22, fix_b23,
                    fix_b31, fix_b32, fix_b33};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= (state_reg == DONE);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == 4'd8)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 9; n++) begin
                a_lat_reg[n] <= '0;
                b_lat_reg[n] <= '0;
            end
        end else if (load) begin
            a_lat_reg <= a_in;
            b_lat_reg <= b_in;
        end
    end

    // Row k receives a_ik at RUN cycle i+k; every other slot injects zero.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            a_edge[k] = '0;
            if (state_reg == RUN && int'(cnt_reg) >= k && int'(cnt_reg) - k < 3)
                a_edge[k] = ext(a_lat_reg[(int'(cnt_reg) - k) * 3 + k]);
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            for (gj = 0; gj < 3; gj++) begin : g_col
                logic [ACC_W-1:0] a_reg, psum_reg;
                logic [ACC_W-1:0] a_cur, psum_in;
                if (gj == 0) begin : g_left
                    assign a_cur = a_edge[gi];
                end else begin : g_inner
                    assign a_cur = pe_a[gi][gj-1];
                end
                if (gi == 0) begin : g_top
                    assign psum_in = '0;
                end else begin : g_below
                    assign psum_in = pe_psum[gi-1][gj];
                end
                always_ff @(posedge clk) begin
                    if (reset) begin
                        a_reg    <= '0;
                        psum_reg <= '0;
                    end else begin
                        a_reg    <= a_cur;
                        psum_reg <= psum_in + a_cur * ext(b_lat_reg[gi*3+gj]);
                    end
                end
                assign pe_a[gi][gj]    = a_reg;
                assign pe_psum[gi][gj] = psum_reg;
            end
        end
    endgenerate

    // De-skew: c_ij leaves the bottom of column j during RUN cycle i+j+3.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 9; n++) begin
                shadow_reg[n] <= '0;
                c_reg[n]      <= '0;
            end
        end else begin
            if (state_reg == RUN) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        if (int'(cnt_reg) == i + j + 3)
                            shadow_reg[i*3+j] <= pe_psum[2][j];
            end
            if (state_reg == DONE)
                c_reg <= shadow_reg;
        end
    end

    assign {c11, c12, c13} = {c_reg[0], c_reg[1], c_reg[2]};
    assign {c21, c22, c23} = {c_reg[3], c_reg[4], c_reg[5]};
    assign {c31, c32, c33} = {c_reg[6], c_reg[7], c_reg[8]};
    assign busy = (state_reg != IDLE);
    assign done = done_reg;
endmodule
